// File: rtl/mac_table_maint_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mac_table_maint_ctrl
// Description : Maintenance controller for the MAC address table. Triggers
//               periodic garbage collection, walks the table to flush the
//               entries learned on one port, and arbitrates the single
//               management port between the flush engine and a host.
//               Optional statistics counters: define MAC_MAINT_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_table_maint_ctrl #(
  parameter int GC_INTERVAL = 156250000,
  parameter int ADDR_BITS   = 11,
  parameter int WAY_COUNT   = 8,
  parameter int PORT_BITS   = 5,
  localparam int c_WAY_BITS = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  gc_timer_en,
  output logic                  tbl_gc_en,
  input  logic                  tbl_gc_done,
  output logic                  tbl_rd_en,
  output logic                  tbl_del_en,
  output logic [ADDR_BITS-1:0]  tbl_addr,
  output logic [c_WAY_BITS-1:0] tbl_way,
  input  logic                  tbl_ack,
  input  logic                  tbl_rd_valid,
  input  logic [PORT_BITS-1:0]  tbl_rd_port,
  output logic                  host_ready,
  input  logic                  host_rd_en,
  input  logic                  host_del_en,
  input  logic [ADDR_BITS-1:0]  host_addr,
  input  logic [c_WAY_BITS-1:0] host_way,
  output logic                  host_ack,
  input  logic                  flush_req,
  input  logic [PORT_BITS-1:0]  flush_port,
  output logic                  flush_busy,
  output logic                  flush_done,
  output logic                  gc_busy,
  output logic [31:0]           stat_flushed,
  output logic [31:0]           stat_gc_runs
);

  localparam int                    c_TMR_BITS = $clog2(GC_INTERVAL);
  localparam logic [c_TMR_BITS-1:0] c_TMR_LAST = c_TMR_BITS'(GC_INTERVAL - 1);
  localparam logic [c_WAY_BITS-1:0] c_WAY_LAST = c_WAY_BITS'(WAY_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_HOST_WAIT   = 3'd1,
    S_FL_RD_WAIT  = 3'd2,
    S_FL_DEL_WAIT = 3'd3,
    S_GC_WAIT     = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_live;
  logic [c_TMR_BITS-1:0]   r_timer;
  logic                    r_gc_pending;
  logic                    r_flush_active;
  logic [PORT_BITS-1:0]    r_flush_port;
  logic [ADDR_BITS-1:0]    r_cur_addr;
  logic [c_WAY_BITS-1:0]   r_cur_way;
  logic [ADDR_BITS-1:0]    r_op_addr;
  logic [c_WAY_BITS-1:0]   r_op_way;

  logic                    w_expire;
  logic                    w_gc_req;
  logic                    w_last;
  logic                    w_flush_done;
  logic                    w_tbl_rd_en;
  logic                    w_tbl_del_en;
  logic                    w_tbl_gc_en;
  logic [ADDR_BITS-1:0]    w_addr;
  logic [c_WAY_BITS-1:0]   w_way;
  logic                    w_load_op;
  logic                    w_host_ack;
  logic                    w_adv;

  assign w_expire     = gc_timer_en && (r_timer == c_TMR_LAST);
  // An expiry in the same cycle as an idle FSM starts GC without a pending bubble.
  assign w_gc_req     = r_gc_pending || w_expire;
  assign w_last       = (&r_cur_addr) && (r_cur_way == c_WAY_LAST);
  assign w_flush_done = w_adv && w_last;

  // r_live gates every combinational output so nothing leaks out while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  // GC interval timer and sticky pending request; repeated expiries coalesce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer      <= '0;
      r_gc_pending <= 1'b0;
    end else begin
      if (gc_timer_en) r_timer <= w_expire ? '0 : r_timer + 1'b1;
      if (w_tbl_gc_en)   r_gc_pending <= 1'b0;
      else if (w_expire) r_gc_pending <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and management-port drive; host beats flush beats GC in IDLE.
  always_comb begin
    w_state_nxt  = r_state;
    w_tbl_rd_en  = 1'b0;
    w_tbl_del_en = 1'b0;
    w_tbl_gc_en  = 1'b0;
    w_addr       = r_op_addr;
    w_way        = r_op_way;
    w_load_op    = 1'b0;
    w_host_ack   = 1'b0;
    w_adv        = 1'b0;
    if (r_live) begin
      case (r_state)
        S_IDLE: begin
          w_addr = '0;
          w_way  = '0;
          if (host_rd_en || host_del_en) begin
            w_tbl_rd_en  = host_rd_en;
            w_tbl_del_en = ~host_rd_en;
            w_addr       = host_addr;
            w_way        = host_way;
            w_load_op    = 1'b1;
            w_state_nxt  = S_HOST_WAIT;
          end else if (r_flush_active) begin
            w_tbl_rd_en  = 1'b1;
            w_addr       = r_cur_addr;
            w_way        = r_cur_way;
            w_load_op    = 1'b1;
            w_state_nxt  = S_FL_RD_WAIT;
          end else if (w_gc_req) begin
            w_tbl_gc_en  = 1'b1;
            w_state_nxt  = S_GC_WAIT;
          end
        end
        S_HOST_WAIT: begin
          if (tbl_ack) begin
            w_host_ack  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_FL_RD_WAIT: begin
          if (tbl_ack) begin
            if (tbl_rd_valid && (tbl_rd_port == r_flush_port)) begin
              w_tbl_del_en = 1'b1;
              w_state_nxt  = S_FL_DEL_WAIT;
            end else begin
              w_adv        = 1'b1;
              w_state_nxt  = S_IDLE;
            end
          end
        end
        S_FL_DEL_WAIT: begin
          if (tbl_ack) begin
            w_adv       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_GC_WAIT: begin
          if (tbl_gc_done) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Hold addr/way of the issued operation until its acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_addr <= '0;
      r_op_way  <= '0;
    end else if (w_load_op) begin
      r_op_addr <= w_addr;
      r_op_way  <= w_way;
    end
  end

  // Flush cursor walk; a request coinciding with the final entry restarts the walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_active <= 1'b0;
      r_flush_port   <= '0;
      r_cur_addr     <= '0;
      r_cur_way      <= '0;
    end else begin
      if (w_adv) begin
        if (w_last) begin
          r_flush_active <= 1'b0;
          r_cur_addr     <= '0;
          r_cur_way      <= '0;
        end else if (r_cur_way == c_WAY_LAST) begin
          r_cur_way  <= '0;
          r_cur_addr <= r_cur_addr + 1'b1;
        end else begin
          r_cur_way  <= r_cur_way + 1'b1;
        end
      end
      if (flush_req && (!r_flush_active || w_flush_done)) begin
        r_flush_active <= 1'b1;
        r_flush_port   <= flush_port;
      end
    end
  end

`ifdef MAC_MAINT_STATS_EN
  logic [31:0] r_stat_flushed;
  logic [31:0] r_stat_gc_runs;

  // Wrapping statistics counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_flushed <= '0;
      r_stat_gc_runs <= '0;
    end else begin
      if ((r_state == S_FL_DEL_WAIT) && tbl_ack)   r_stat_flushed <= r_stat_flushed + 32'd1;
      if ((r_state == S_GC_WAIT) && tbl_gc_done)   r_stat_gc_runs <= r_stat_gc_runs + 32'd1;
    end
  end

  assign stat_flushed = r_stat_flushed;
  assign stat_gc_runs = r_stat_gc_runs;
`else
  assign stat_flushed = '0;
  assign stat_gc_runs = '0;
`endif

  assign tbl_rd_en  = w_tbl_rd_en;
  assign tbl_del_en = w_tbl_del_en;
  assign tbl_gc_en  = w_tbl_gc_en;
  assign tbl_addr   = w_addr;
  assign tbl_way    = w_way;
  assign host_ready = r_live && (r_state == S_IDLE);
  assign host_ack   = w_host_ack;
  assign flush_busy = r_flush_active;
  assign flush_done = w_flush_done;
  assign gc_busy    = (r_state == S_GC_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_mac_table_maint_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_table_maint_ctrl
// Description : Directed self-checking bench for mac_table_maint_ctrl with a
//               small behavioural table model (8 entries, 2 ways x 4 rows).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_table_maint_ctrl;

  localparam int GC_INTERVAL = 100;
  localparam int ADDR_BITS   = 2;
  localparam int WAY_COUNT   = 2;
  localparam int PORT_BITS   = 5;
  localparam int WAY_BITS    = 1;
`ifdef MAC_MAINT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 gc_timer_en;
  logic                 tbl_gc_en;
  logic                 tbl_gc_done;
  logic                 tbl_rd_en;
  logic                 tbl_del_en;
  logic [ADDR_BITS-1:0] tbl_addr;
  logic [WAY_BITS-1:0]  tbl_way;
  logic                 tbl_ack;
  logic                 tbl_rd_valid;
  logic [PORT_BITS-1:0] tbl_rd_port;
  logic                 host_ready;
  logic                 host_rd_en;
  logic                 host_del_en;
  logic [ADDR_BITS-1:0] host_addr;
  logic [WAY_BITS-1:0]  host_way;
  logic                 host_ack;
  logic                 flush_req;
  logic [PORT_BITS-1:0] flush_port;
  logic                 flush_busy;
  logic                 flush_done;
  logic                 gc_busy;
  logic [31:0]          stat_flushed;
  logic [31:0]          stat_gc_runs;

  always #5 clk = ~clk;

  mac_table_maint_ctrl #(
    .GC_INTERVAL(GC_INTERVAL), .ADDR_BITS(ADDR_BITS),
    .WAY_COUNT(WAY_COUNT), .PORT_BITS(PORT_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .gc_timer_en(gc_timer_en),
    .tbl_gc_en(tbl_gc_en), .tbl_gc_done(tbl_gc_done),
    .tbl_rd_en(tbl_rd_en), .tbl_del_en(tbl_del_en),
    .tbl_addr(tbl_addr), .tbl_way(tbl_way), .tbl_ack(tbl_ack),
    .tbl_rd_valid(tbl_rd_valid), .tbl_rd_port(tbl_rd_port),
    .host_ready(host_ready), .host_rd_en(host_rd_en), .host_del_en(host_del_en),
    .host_addr(host_addr), .host_way(host_way), .host_ack(host_ack),
    .flush_req(flush_req), .flush_port(flush_port),
    .flush_busy(flush_busy), .flush_done(flush_done), .gc_busy(gc_busy),
    .stat_flushed(stat_flushed), .stat_gc_runs(stat_gc_runs)
  );

  // Table model: an op issued in cycle C is acknowledged in cycle C+ack_lat;
  // a GC started in cycle G reports done in cycle G+gc_lat.
  int             ack_lat = 2;
  int             gc_lat  = 10;
  logic           mem_valid [8];
  logic [4:0]     mem_port  [8];
  logic           pend;
  logic           was_rd;
  int             wait_cnt;
  int             idx;
  int             gc_cnt;
  int             rd_log[$];
  int             del_log[$];

  always @(posedge clk) begin
    tbl_ack      <= 1'b0;
    tbl_rd_valid <= 1'b0;
    tbl_rd_port  <= '0;
    tbl_gc_done  <= 1'b0;
    if (!rst_n) begin
      pend     <= 1'b0;
      was_rd   <= 1'b0;
      wait_cnt <= 0;
      idx      <= 0;
      gc_cnt   <= 0;
    end else begin
      if (pend) begin
        if (wait_cnt == 0) begin
          tbl_ack <= 1'b1;
          if (was_rd) begin
            tbl_rd_valid <= mem_valid[idx];
            tbl_rd_port  <= mem_port[idx];
          end
          pend <= 1'b0;
        end else begin
          wait_cnt <= wait_cnt - 1;
        end
      end else if (tbl_rd_en || tbl_del_en) begin
        pend     <= 1'b1;
        wait_cnt <= ack_lat - 2;
        was_rd   <= tbl_rd_en;
        idx      <= int'({tbl_addr, tbl_way});
        if (tbl_rd_en) rd_log.push_back(int'({tbl_addr, tbl_way}));
        else           del_log.push_back(int'({tbl_addr, tbl_way}));
      end
      if (gc_cnt != 0) begin
        if (gc_cnt == 1) tbl_gc_done <= 1'b1;
        gc_cnt <= gc_cnt - 1;
      end else if (tbl_gc_en) begin
        gc_cnt <= gc_lat - 1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int  done_seen, n_done, gap, n_ack, max_lat, t0, found, n, bad, early_gc, order_ok;

  initial begin
    rst_n = 1'b0; gc_timer_en = 1'b0; host_rd_en = 1'b0; host_del_en = 1'b0;
    host_addr = '0; host_way = '0; flush_req = 1'b0; flush_port = '0;
    // idx = {addr,way}: (1,0)=2 and (3,1)=7 hold port 7; idx 4 is invalid with port 7
    mem_valid[0] = 1; mem_port[0] = 2;
    mem_valid[1] = 0; mem_port[1] = 2;
    mem_valid[2] = 1; mem_port[2] = 7;
    mem_valid[3] = 1; mem_port[3] = 2;
    mem_valid[4] = 0; mem_port[4] = 7;
    mem_valid[5] = 1; mem_port[5] = 3;
    mem_valid[6] = 0; mem_port[6] = 2;
    mem_valid[7] = 1; mem_port[7] = 7;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    host_rd_en = 1'b1; #1;
    check("rst_host_ready", host_ready, 0);
    check("rst_rd_en", tbl_rd_en, 0);
    check("rst_flush_busy", flush_busy, 0);
    check("rst_gc_en", tbl_gc_en, 0);
    host_rd_en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    check("idle_host_ready", host_ready, 1);
    check("idle_rd_en", tbl_rd_en, 0);
    check("idle_del_en", tbl_del_en, 0);
    check("idle_gc_busy", gc_busy, 0);
    check("idle_stat_flushed", stat_flushed, 0);
    check("idle_stat_gc", stat_gc_runs, 0);

    // ---- host read, 4-cycle table latency ----
    ack_lat = 4;
    @(negedge clk); host_rd_en = 1'b1; host_addr = 2; host_way = 1; #1;
    check("hrd_issue", tbl_rd_en, 1);
    check("hrd_addr", tbl_addr, 2);
    check("hrd_way", tbl_way, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); host_rd_en = 1'b0; #1;
      check("hrd_wait_ready", host_ready, 0);
      check("hrd_hold_addr", tbl_addr, 2);
      check("hrd_ack", host_ack, (k == 4) ? 1 : 0);
      if (k == 4) begin
        check("hrd_valid", tbl_rd_valid, 1);
        check("hrd_port", tbl_rd_port, 3);
      end
    end
    @(negedge clk); #1;
    check("hrd_ready_back", host_ready, 1);
    check("hrd_ack_gone", host_ack, 0);

    // ---- read wins when both host enables are high ----
    ack_lat = 2;
    @(negedge clk); host_rd_en = 1'b1; host_del_en = 1'b1; host_addr = 1; host_way = 0; #1;
    check("both_rd", tbl_rd_en, 1);
    check("both_del", tbl_del_en, 0);
    @(negedge clk); host_rd_en = 1'b0; host_del_en = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge clk); #1;
      if (host_ack) found = 1;
    end
    check("both_ack_seen", found, 1);

    // ---- flush of port 7, with an ignored flush_req mid-walk ----
    rd_log.delete(); del_log.delete(); n_done = 0;
    @(negedge clk); flush_req = 1'b1; flush_port = 7;
    @(negedge clk); flush_req = 1'b0; #1;
    check("fl1_busy", flush_busy, 1);
    done_seen = 0;
    for (int c = 0; c < 200 && done_seen == 0; c++) begin
      @(negedge clk);
      if (c == 5) begin flush_req = 1'b1; flush_port = 2; end
      else flush_req = 1'b0;
      #1;
      if (flush_done) begin done_seen = 1; n_done++; end
    end
    flush_req = 1'b0;
    check("fl1_done_seen", done_seen, 1);
    repeat (5) begin
      @(negedge clk); #1;
      if (flush_done) n_done++;
    end
    check("fl1_done_count", n_done, 1);
    check("fl1_busy_end", flush_busy, 0);
    check("fl1_reads", rd_log.size(), 8);
    order_ok = 1;
    for (int i = 0; i < 8; i++) if (rd_log.size() <= i || rd_log[i] != i) order_ok = 0;
    check("fl1_read_order", order_ok, 1);
    check("fl1_dels", del_log.size(), 2);
    check("fl1_del0", (del_log.size() > 0) ? del_log[0] : -1, 2);
    check("fl1_del1", (del_log.size() > 1) ? del_log[1] : -1, 7);
    check("fl1_stat", stat_flushed, STATS ? 2 : 0);

    // ---- flush with host deletes interleaved; restart on flush_done ----
    rd_log.delete(); del_log.delete();
    @(negedge clk); flush_req = 1'b1; flush_port = 7;
    @(negedge clk); flush_req = 1'b0;
    done_seen = 0; gap = 0; n_ack = 0; max_lat = 0; t0 = 0;
    for (int c = 0; c < 400 && done_seen == 0; c++) begin
      @(negedge clk);
      if (!host_del_en && gap == 0) begin
        host_del_en = 1'b1; host_addr = 3; host_way = 0; t0 = c;
      end
      gap = 0;
      #1;
      if (host_ack) begin
        n_ack++;
        if (c - t0 > max_lat) max_lat = c - t0;
        host_del_en = 1'b0; gap = 1;
      end
      if (flush_done) begin done_seen = 1; flush_req = 1'b1; flush_port = 7; end
    end
    @(negedge clk); flush_req = 1'b0; host_del_en = 1'b0; #1;
    check("fl2_done_seen", done_seen, 1);
    check("fl2_host_acks", n_ack >= 3, 1);
    check("fl2_host_latency", max_lat <= 6, 1);
    order_ok = 1;
    for (int i = 0; i < 8; i++) if (rd_log.size() <= i || rd_log[i] != i) order_ok = 0;
    check("fl2_read_order", order_ok, 1);
    check("fl2_restart_busy", flush_busy, 1);

    // ---- reset while in FL_DEL_WAIT ----
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      @(negedge clk); #1;
      if (tbl_del_en) found = 1;
    end
    check("rstdel_del_seen", found, 1);
    check("rstdel_del_addr", tbl_addr, 1);
    check("rstdel_del_way", tbl_way, 0);
    @(negedge clk); #1;
    check("rstdel_in_wait_addr", tbl_addr, 1);
    rst_n = 1'b0; #1;
    check("rstdel_busy", flush_busy, 0);
    check("rstdel_addr", tbl_addr, 0);
    check("rstdel_ready", host_ready, 0);
    check("rstdel_stat", stat_flushed, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); flush_req = 1'b1; flush_port = 7; #1;
    check("rstdel_no_early_rd", tbl_rd_en, 0);
    @(negedge clk); flush_req = 1'b0; #1;
    check("rstdel_restart_rd", tbl_rd_en, 1);
    check("rstdel_restart_addr", tbl_addr, 0);
    check("rstdel_restart_way", tbl_way, 0);

    // ---- GC interval: pulses at cycle 99 and 199, busy for 10 cycles ----
    @(negedge clk); rst_n = 1'b0; gc_timer_en = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    found = 0; n = 0;
    for (int c = 1; c <= 150 && found == 0; c++) begin
      @(posedge clk); #1;
      if (tbl_gc_en) begin found = 1; n = c; end
    end
    check("gc1_cycle", n, 99);
    bad = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (gc_busy !== 1'b1) bad++;
      if (k == 10) check("gc1_done_pulse", tbl_gc_done, 1);
    end
    check("gc1_busy_window", bad, 0);
    @(posedge clk); #1;
    check("gc1_busy_end", gc_busy, 0);
    check("gc1_stat", stat_gc_runs, STATS ? 1 : 0);
    found = 0; n = 0;
    for (int c = 111; c <= 260 && found == 0; c++) begin
      @(posedge clk); #1;
      if (tbl_gc_en) begin found = 1; n = c; end
    end
    check("gc2_cycle", n, 199);

    // ---- timer expiry during a flush: GC right after flush_done ----
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    done_seen = 0; early_gc = 0;
    for (int c = 1; c <= 300 && done_seen == 0; c++) begin
      @(posedge clk); #1;
      if (c == 90) begin flush_req = 1'b1; flush_port = 7; end
      if (c == 91) flush_req = 1'b0;
      if (tbl_gc_en) early_gc = 1;
      if (flush_done) done_seen = 1;
    end
    check("gcfl_done_seen", done_seen, 1);
    check("gcfl_no_early_gc", early_gc, 0);
    @(posedge clk); #1;
    check("gcfl_gc_after_done", tbl_gc_en, 1);
    @(posedge clk); #1;
    check("gcfl_gc_busy", gc_busy, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
